// File: rtl/nibble_serializer.sv
// nibble_serializer: parallel-to-serial frame source with a 2-entry holding buffer.
// Each word is sent MSB first on a registered serial line, followed by one
// idle gap cycle. The gap cycle carries a frame_done pulse.
// Optional feature macro: SERIALIZER_PARITY_EN. When it is defined, an even-parity
// bit is sent after the data bits and before the gap.
module nibble_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             data_out,
  output logic             busy,
  output logic             frame_done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;

  state_e                  state_q, state_d;
  logic [1:0][WIDTH-1:0]   mem_q, mem_d;
  logic                    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]              count_q, count_d;
  logic                    load_ready_q, load_ready_d;
  logic [WIDTH-1:0]        shift_q, shift_d;
  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic                    data_out_q, data_out_d;
  logic                    frame_done_q, frame_done_d;
`ifdef SERIALIZER_PARITY_EN
  logic                    parity_q, parity_d;
`endif

  logic                    accept, push, pop, bypass, load_sh;
  logic [WIDTH-1:0]        load_word;

  // Ready is a flop of the buffer occupancy, so a pop never opens it combinationally.
  assign accept     = load_valid && load_ready_q;
  assign load_ready = load_ready_q;
  assign data_out   = data_out_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != IDLE) || (count_q != 2'd0);

  // Frame FSM: chooses the next shifter load and the next serial bit.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    data_out_d   = 1'b0;
    frame_done_d = 1'b0;
    pop          = 1'b0;
    bypass       = 1'b0;
    load_sh      = 1'b0;
    load_word    = mem_q[rd_ptr_q];
`ifdef SERIALIZER_PARITY_EN
    parity_d     = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (count_q != 2'd0) begin
          pop     = 1'b1;
          load_sh = 1'b1;
        end else if (accept) begin
          // An empty buffer lets the word skip straight into the shifter.
          bypass    = 1'b1;
          load_sh   = 1'b1;
          load_word = load_data;
        end
      end
      SHIFT: begin
        // bit_cnt_q is the index of the bit currently on the line.
        if (bit_cnt_q < LAST_DATA) begin
          data_out_d = shift_q[WIDTH-1];
          shift_d    = shift_q << 1;
          bit_cnt_d  = bit_cnt_q + CW'(1);
        end
`ifdef SERIALIZER_PARITY_EN
        else if (bit_cnt_q == LAST_DATA) begin
          data_out_d = parity_q;
          bit_cnt_d  = LAST_DATA + CW'(1);
        end
`endif
        else begin
          state_d      = GAP;
          frame_done_d = 1'b1;
        end
      end
      GAP: begin
        if (count_q != 2'd0) begin
          pop     = 1'b1;
          load_sh = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load_sh) begin
      state_d    = SHIFT;
      shift_d    = load_word << 1;
      data_out_d = load_word[WIDTH-1];
      bit_cnt_d  = '0;
`ifdef SERIALIZER_PARITY_EN
      parity_d   = ^load_word;
`endif
    end
  end

  // Holding buffer: push any accepted word that did not bypass. Pop on a shifter load.
  always_comb begin
    push         = accept && !bypass;
    mem_d        = mem_q;
    if (push) mem_d[wr_ptr_q] = load_data;
    wr_ptr_d     = wr_ptr_q ^ push;
    rd_ptr_d     = rd_ptr_q ^ pop;
    count_d      = count_q + {1'b0, push} - {1'b0, pop};
    load_ready_d = (count_d < 2'd2);
  end

  // State registers; an asynchronous reset discards the in-flight frame and buffered words.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      mem_q        <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      load_ready_q <= 1'b1;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      data_out_q   <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      load_ready_q <= load_ready_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      data_out_q   <= data_out_d;
      frame_done_q <= frame_done_d;
`ifdef SERIALIZER_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_nibble_serializer.sv
// Testbench for nibble_serializer: a scoreboard of accepted words, checked
// against the serial stream at every frame_done, plus directed timing checks.
module tb_nibble_serializer;
  localparam int W = 4;
`ifdef SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic         clk, reset, load_valid, load_ready, data_out, busy, frame_done;
  logic [W-1:0] load_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] q[$];
  logic [W:0]   hist;

  nibble_serializer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready), .data_out(data_out), .busy(busy), .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard push: record every word the handshake accepts.
  always @(posedge clk)
    if (reset && load_valid && load_ready) q.push_back(load_data);

  // Stream monitor: at each gap, the preceding serial bits must form the oldest expected word.
  always @(negedge clk) begin
    if (!reset) begin
      hist = '0;
      q.delete();
    end else begin
      if (frame_done) begin
        chk("gap_zero", {31'd0, data_out}, 32'd0);
        if (q.size() == 0) chk("sb_extra_frame", 32'd1, 32'd0);
        else begin
          logic [W-1:0] w;
          logic [31:0]  got, exp;
          w = q.pop_front();
          if (PAR != 0) begin
            got = {{(31-W){1'b0}}, hist};
            exp = {{(31-W){1'b0}}, w, ^w};
          end else begin
            got = {{(32-W){1'b0}}, hist[W-1:0]};
            exp = {{(32-W){1'b0}}, w};
          end
          chk("frame_bits", got, exp);
        end
      end
      hist = {hist[W-1:0], data_out};
    end
  end

  initial begin
    logic [W-1:0] sw;
    logic [W-1:0] words[12];
    int nfd, t;
    logic any;

    reset = 1'b0; load_valid = 1'b0; load_data = '0;
    // Reset values while reset is held low
    @(negedge clk);
    chk("rst_ready", {31'd0, load_ready}, 32'd1);
    chk("rst_dout",  {31'd0, data_out},   32'd0);
    chk("rst_busy",  {31'd0, busy},       32'd0);
    chk("rst_done",  {31'd0, frame_done}, 32'd0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b1;

    // Single word with exact latency
    sw = 4'b1011;
    @(negedge clk); load_data = sw; load_valid = 1'b1;
    @(posedge clk); #1 load_valid = 1'b0;
    for (int k = 0; k <= W + 1 + PAR; k++) begin
      @(negedge clk);
      if (k < W)            chk("sw_bit", {31'd0, data_out}, {31'd0, sw[W-1-k]});
      else if (k < W + PAR) chk("sw_par", {31'd0, data_out}, {31'd0, ^sw});
      else if (k == W + PAR) chk("sw_gap", {31'd0, data_out}, 32'd0);
      chk("sw_done", {31'd0, frame_done}, {31'd0, (k == W + PAR)});
      if (k == W + 1 + PAR) chk("sw_busy", {31'd0, busy}, 32'd0);
    end

    // Back-to-back words, ready timing, no dead cycles, and a push while not ready
    load_data = 4'b1100; load_valid = 1'b1;
    @(posedge clk); #1 load_data = 4'b0011;
    @(posedge clk); #1 load_data = 4'b1111;
    @(posedge clk); #1 load_valid = 1'b0;
    nfd = 0;
    for (int k = 2; k <= 3 * (W + 1 + PAR); k++) begin
      @(negedge clk);
      if (k == 2) begin
        chk("b2b_ready_lo", {31'd0, load_ready}, 32'd0);
        load_data = 4'b0101; load_valid = 1'b1;
      end
      if (k == W + PAR) begin
        chk("b2b_ready_still_lo", {31'd0, load_ready}, 32'd0);
        load_valid = 1'b0;
      end
      if (k == W + 1 + PAR) chk("b2b_ready_hi", {31'd0, load_ready}, 32'd1);
      if (frame_done) begin
        chk("b2b_fd_cycle", k, (nfd + 1) * (W + 1 + PAR) - 1);
        nfd++;
      end
    end
    chk("b2b_frames", nfd, 3);

    // Reset in the middle of a frame with two words buffered
    load_data = 4'b1111; load_valid = 1'b1;
    @(posedge clk); #1 load_data = 4'b1110;
    @(posedge clk); #1 load_data = 4'b1101;
    @(posedge clk); #1 load_valid = 1'b0;
    @(negedge clk);
    chk("mid_bit2_before", {31'd0, data_out}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_dout",  {31'd0, data_out},   32'd0);
    chk("mid_rst_busy",  {31'd0, busy},       32'd0);
    chk("mid_rst_ready", {31'd0, load_ready}, 32'd1);
    chk("mid_rst_done",  {31'd0, frame_done}, 32'd0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b1;
    any = 1'b0;
    repeat (12) begin
      @(negedge clk);
      any = any | data_out | frame_done | busy;
    end
    chk("mid_quiet_after", {31'd0, any}, 32'd0);

    // Random stream through the scoreboard, starting with the parity pattern
    words[0] = 4'b0111;
    for (int i = 1; i < 12; i++) words[i] = W'($urandom_range(0, 15));
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      t = 0;
      while (!load_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) chk("rnd_ready_timeout", 32'd0, 32'd1);
      load_data = words[i]; load_valid = 1'b1;
      @(posedge clk); #1 load_valid = 1'b0;
      @(negedge clk);
    end

    // Drain and confirm every accepted word was sent
    t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_busy", {31'd0, busy}, 32'd0);
    chk("sb_empty", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
